ff_addsub: RTL and testbench
============================

# ff_addsub

Parametrised modular adder/subtractor for the field-arithmetic layer of the ECC scalar-multiplication datapath. It is the successor to the fixed 255-bit field subtractor and adds an add/subtract mode select, a configurable operand width and modulus, and a limb-serial carry chain for timing closure. Point-add/double sequencers drive it with a start/valid handshake, alongside the field multiplier.

## Interface
- `WIDTH`, 255: operand and result width in bits.
- `LIMB_W`, 64: limb width for the serial carry chain. Local `NLIMB = ceil(WIDTH/LIMB_W)`. The top limb is zero-padded.
- `MODULUS`, 2^255-19: field prime. Must satisfy `MODULUS < 2^WIDTH`.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request strobe. Sampled only while `busy`=0.
- `op`, input, 1: 0 = (a+b) mod p, 1 = (a-b) mod p. Latched with `start`.
- `a`, input, WIDTH: operand, latched with `start`. Required to be < MODULUS.
- `b`, input, WIDTH: operand, latched with `start`. Required to be < MODULUS.
- `busy`, output, 1: high while an operation is in flight.
- `valid`, output, 1: one-cycle pulse when `result` is new.
- `result`, output, WIDTH: registered result. Holds its value until the next `valid`.

## Operation
- FSM states: IDLE, PASS1, PASS2, DONE.
- IDLE: `busy`=0. On `start`=1, latch `a`, `b` and `op`, clear the carry/borrow flag and the limb index, then go to PASS1.
- PASS1, NLIMB cycles: per limb i, compute `s_i = a_i ± b_i ± carry`, store it in the raw register, and propagate carry/borrow. After the last limb, record `c1`:
  - add: carry out of bit WIDTH.
  - sub: borrow.
- PASS2, NLIMB cycles: per limb, compute the correction `t = s ∓ MODULUS`, limb-serial:
  - add: subtract p; record final borrow `c2`.
  - sub: add p.
- Result select at the end of PASS2:
  - add: `result = (c1 | ~c2) ? t : s`. This is a single conditional subtract, and the sum is treated as WIDTH+1 bits.
  - sub: `result = c1 ? t : s`. Add p only on borrow.
- DONE, 1 cycle: `valid`=1, `busy`=0, `result` updated. Next state is IDLE, or PASS1 if `start`=1 in this cycle (back-to-back accepted).
- Arithmetic: all intermediate values are held mod 2^WIDTH, with carry/borrow flags kept separately.
- Out-of-range operands (≥ MODULUS): the result is whatever the single-correction algorithm above produces. It is deterministic, and the latency is unchanged.

## Timing
- Reset (rst=1 at an edge): state IDLE, `busy`=0, `valid`=0, `result`=0, internal registers cleared. This overrides any in-flight operation. No `valid` is produced for an aborted operation.
- Latency: with `start` sampled at edge k, `valid`=1 during the cycle following edge k+2·NLIMB+1. For the defaults (NLIMB=4) this is edge k+9.
- `busy` rises after edge k and falls after edge k+2·NLIMB+1, so it is low during the DONE cycle.
- `start` while `busy`=1 is ignored. Inputs are not re-sampled.
- `start` during the DONE cycle is accepted. The next `valid` follows exactly 2·NLIMB+1 edges later.
- `a`, `b` and `op` may change freely after the sampling edge.
- Throughput: one operation per 2·NLIMB+1 cycles.

## Test plan
- Add with wrap: default params, `a`=p-1, `b`=2, `op`=0 -> `result`=1, `valid` at edge k+9, `busy` high for 9 cycles.
- Add at the max-carry corner: `a`=`b`=p-1, `op`=0 -> `result`=p-2 (exercises the 256-bit carry). Also `a`=`b`=0 -> 0.
- Subtract with borrow: `a`=5, `b`=7, `op`=1 -> `result`=p-2. Then `a`=7, `b`=5 -> 2, and `a`=`b`=p-1 -> 0.
- Handshake:
  - `start` pulsed at edge k+3 mid-operation -> ignored, exactly one `valid`.
  - `start` asserted in the DONE cycle with `a`=1, `b`=1, add -> second `valid` with `result`=2 exactly 9 edges later.
- Reset mid-operation: `rst`=1 for one edge during PASS2 -> next cycle `busy`=0, `valid`=0, `result`=0. No `valid` follows. A new `start` afterwards works normally.
- Parameter sweep: `WIDTH`=16, `LIMB_W`=5, `MODULUS`=65521 (NLIMB=4):
  - `a`=65520, `b`=1, add -> 0.
  - `a`=0, `b`=1, sub -> 65520.
  - 1000 random reduced-operand operations checked against a reference model.

Source files
------------

// File: rtl/ff_addsub.sv
// ff_addsub -- limb-serial modular adder/subtractor for the ECC field layer.
//
// Computes (a+b) mod MODULUS (op=0) or (a-b) mod MODULUS (op=1) using one
// LIMB_W-bit adder that is reused across limbs. An operation takes two
// serial passes over NLIMB limbs plus one result-select cycle:
//   PASS1 : s = a +/- b          (raw result, flag c1)
//   PASS2 : t = s -/+ MODULUS    (correction, flag c2 for add)
//   select: add -> (c1 | ~c2) ? t : s ; sub -> c1 ? t : s
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, aborts any operation in flight
//   start  : request strobe, sampled only while busy=0 (IDLE or DONE)
//   op     : 0 = add, 1 = subtract, latched with start
//   a, b   : operands (expected < MODULUS), latched with start
//   busy   : high from the edge after start until the result is selected
//   valid  : one-cycle pulse while result is new (DONE state)
//   result : registered result, held until the next valid
//
// Handshake: a request is accepted on any rising edge where start=1 and
// busy=0. Exactly one valid pulse follows 2*NLIMB+1 edges later unless rst
// intervenes. start while busy=1 is ignored and inputs are not re-sampled.
module ff_addsub #(
  parameter int              WIDTH   = 255,
  parameter int              LIMB_W  = 64,
  parameter logic [WIDTH-1:0] MODULUS = {WIDTH{1'b1}} - WIDTH'(18)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int NLIMB = (WIDTH + LIMB_W - 1) / LIMB_W;
  localparam int PW    = NLIMB * LIMB_W;           // zero-padded width
  localparam int IW    = $clog2(NLIMB + 1);

  localparam logic [IW-1:0] LAST_LIMB = IW'(NLIMB - 1);
  localparam logic [IW-1:0] SEL_STEP  = IW'(NLIMB);

  localparam logic [PW-1:0] ONE_PW = PW'(1);
  // Low WIDTH bits set: keeps intermediate values mod 2^WIDTH.
  localparam logic [PW-1:0] WMASK  = (ONE_PW << WIDTH) - ONE_PW;
  localparam logic [PW-1:0] LMASK  = (ONE_PW << LIMB_W) - ONE_PW;
  localparam logic [PW-1:0] PMOD   = PW'(MODULUS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          cy;      // running carry/borrow of the active pass
  logic          c1;      // carry/borrow out of PASS1
  logic          op_r;
  logic [PW-1:0] ra, rb, rs, rt;

  // Limb datapath
  logic [PW-1:0]     sm;
  int unsigned       off;
  logic [LIMB_W-1:0] x, y;
  logic              do_sub;
  logic [LIMB_W:0]   sum;
  logic [PW-1:0]     limb_mask, limb_val;
  logic              c1_eff;
  logic [PW-1:0]     sel;

  always_comb begin
    sm     = rs & WMASK;
    off    = (idx < SEL_STEP) ? (int'(idx) * LIMB_W) : 0;
    x      = '0;
    y      = '0;
    do_sub = 1'b0;
    if (state == PASS1) begin
      x      = LIMB_W'(ra >> off);
      y      = LIMB_W'(rb >> off);
      do_sub = op_r;
    end else begin
      // PASS2 applies the opposite operation with the modulus.
      x      = LIMB_W'(sm >> off);
      y      = LIMB_W'(PMOD >> off);
      do_sub = ~op_r;
    end
    if (do_sub)
      sum = {1'b0, x} - {1'b0, y} - {{LIMB_W{1'b0}}, cy};
    else
      sum = {1'b0, x} + {1'b0, y} + {{LIMB_W{1'b0}}, cy};
    limb_mask = LMASK << off;
    limb_val  = PW'(sum[LIMB_W-1:0]) << off;

    // With a padded top limb the add carry out of bit WIDTH lands in the
    // padding rather than leaving the top limb.
    c1_eff = c1 | (|(rs & ~WMASK));
    if (!op_r)
      sel = (c1_eff | ~cy) ? rt : sm;   // cy holds the PASS2 borrow here
    else
      sel = c1 ? rt : sm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      cy     <= 1'b0;
      c1     <= 1'b0;
      op_r   <= 1'b0;
      ra     <= '0;
      rb     <= '0;
      rs     <= '0;
      rt     <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ra    <= PW'(a);
            rb    <= PW'(b);
            op_r  <= op;
            cy    <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= PASS1;
          end else begin
            state <= IDLE;
          end
        end
        PASS1: begin
          rs <= (rs & ~limb_mask) | limb_val;
          if (idx == LAST_LIMB) begin
            c1    <= sum[LIMB_W];
            cy    <= 1'b0;
            idx   <= '0;
            state <= PASS2;
          end else begin
            cy  <= sum[LIMB_W];
            idx <= idx + 1'b1;
          end
        end
        PASS2: begin
          if (idx == SEL_STEP) begin
            result <= WIDTH'(sel);
            valid  <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            rt  <= (rt & ~limb_mask) | limb_val;
            cy  <= sum[LIMB_W];
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_addsub.sv
module tb_ff_addsub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: 255-bit, p = 2^255-19
  logic         start0 = 1'b0, op0 = 1'b0;
  logic [254:0] a0 = '0, b0 = '0;
  logic         busy0, valid0;
  logic [254:0] res0;

  // Small instance: 16-bit, 5-bit limbs, p = 65521
  logic        start1 = 1'b0, op1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        busy1, valid1;
  logic [15:0] res1;

  ff_addsub u0 (
    .clk(clk), .rst(rst), .start(start0), .op(op0), .a(a0), .b(b0),
    .busy(busy0), .valid(valid0), .result(res0)
  );

  ff_addsub #(.WIDTH(16), .LIMB_W(5), .MODULUS(16'd65521)) u1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .valid(valid1), .result(res1)
  );

  localparam logic [255:0] P0 = (256'd1 << 255) - 256'd19;
  localparam logic [254:0] PL = 255'((256'd1 << 255) - 256'd19);
  localparam int           P1 = 65521;

  int n_cmp = 0;
  int n_bad = 0;

  logic [254:0] exp_q0[$];
  logic [15:0]  exp_q1[$];

  // ---------------- reference model ----------------
  function automatic logic [254:0] mdl0(input logic o, input logic [254:0] x, input logic [254:0] y);
    logic [255:0] r;
    if (!o) r = ({1'b0, x} + {1'b0, y}) % P0;
    else    r = ({1'b0, x} + P0 - {1'b0, y}) % P0;
    return r[254:0];
  endfunction

  function automatic logic [15:0] mdl1(input logic o, input logic [15:0] x, input logic [15:0] y);
    int r;
    if (!o) r = (int'(x) + int'(y)) % P1;
    else    r = (int'(x) + P1 - int'(y)) % P1;
    return 16'(r);
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (!rst && valid0) begin
      n_cmp++;
      if (exp_q0.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid0 actual=%0h required=none", res0);
      end else begin
        logic [254:0] e;
        e = exp_q0.pop_front();
        if (res0 !== e) begin
          n_bad++;
          $display("FAIL sb0_result actual=%0h required=%0h", res0, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid1) begin
      n_cmp++;
      if (exp_q1.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid1 actual=%0h required=none", res1);
      end else begin
        logic [15:0] e;
        e = exp_q1.pop_front();
        if (res1 !== e) begin
          n_bad++;
          $display("FAIL sb1_result actual=%0h required=%0h", res1, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge: presents a request sampled at the next posedge.
  task automatic issue0(input logic o, input logic [254:0] x, input logic [254:0] y, input bit push);
    op0 = o; a0 = x; b0 = y; start0 = 1'b1;
    if (push) exp_q0.push_back(mdl0(o, x, y));
  endtask

  // Waits for valid, checking latency, busy profile and the literal result.
  task automatic wait0(input string nm, input bit mid, input logic [254:0] lit);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    start0 = 1'b0;
    a0 = '1; b0 = '1; op0 = ~op0;   // inputs are free after sampling
    cyc = 0;
    busy_ok = 1'b1;
    while (!valid0 && cyc < 40) begin
      if (!busy0) busy_ok = 1'b0;
      if (mid && cyc == 2) begin
        start0 = 1'b1; a0 = 255'd11; b0 = 255'd22; op0 = 1'b0;
      end
      if (cyc == 3) start0 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, 256'(cyc), 256'd9);
    chk({nm, "_busy_high"}, 256'(busy_ok), 256'd1);
    chk({nm, "_busy_done"}, 256'(busy0), 256'd0);
    chk({nm, "_result"}, 256'(res0), 256'(lit));
  endtask

  task automatic run0(input string nm, input logic o, input logic [254:0] x, input logic [254:0] y,
                      input logic [254:0] lit, input bit mid);
    @(negedge clk);
    issue0(o, x, y, 1'b1);
    chk({nm, "_model"}, 256'(mdl0(o, x, y)), 256'(lit));
    wait0(nm, mid, lit);
  endtask

  task automatic run1(input string nm, input logic o, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] lit, input bit use_lit);
    int cyc;
    @(negedge clk);
    op1 = o; a1 = x; b1 = y; start1 = 1'b1;
    exp_q1.push_back(mdl1(o, x, y));
    if (use_lit) chk({nm, "_model"}, 256'(mdl1(o, x, y)), 256'(lit));
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (!valid1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (use_lit || cyc != 9) chk({nm, "_latency"}, 256'(cyc), 256'd9);
    if (use_lit) chk({nm, "_result"}, 256'(res1), 256'(lit));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy0", 256'(busy0), 256'd0);
    chk("rst_valid0", 256'(valid0), 256'd0);
    chk("rst_result0", 256'(res0), 256'd0);
    chk("rst_busy1", 256'(busy1), 256'd0);
    chk("rst_result1", 256'(res1), 256'd0);
    rst = 1'b0;
    idle(2);

    run0("add_wrap",   1'b0, PL - 255'd1, 255'd2,      255'd1,      1'b0);
    run0("add_max",    1'b0, PL - 255'd1, PL - 255'd1, PL - 255'd2, 1'b0);
    run0("add_zero",   1'b0, 255'd0,      255'd0,      255'd0,      1'b0);
    run0("sub_borrow", 1'b1, 255'd5,      255'd7,      PL - 255'd2, 1'b0);
    run0("sub_plain",  1'b1, 255'd7,      255'd5,      255'd2,      1'b0);
    run0("sub_equal",  1'b1, PL - 255'd1, PL - 255'd1, 255'd0,      1'b0);
    idle(3);

    // start pulsed mid-operation must be ignored
    run0("mid_ignore", 1'b0, 255'd3, 255'd4, 255'd7, 1'b1);
    idle(12);

    // back-to-back: new request presented in the DONE cycle
    run0("b2b_first", 1'b1, 255'd10, 255'd3, 255'd7, 1'b0);
    issue0(1'b0, 255'd1, 255'd1, 1'b1);
    wait0("b2b_second", 1'b0, 255'd2);
    idle(15);

    // reset during PASS2 aborts without a valid
    @(negedge clk);
    issue0(1'b0, 255'd40, 255'd50, 1'b0);
    @(negedge clk);
    start0 = 1'b0;
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 256'(busy0), 256'd0);
    chk("abort_valid", 256'(valid0), 256'd0);
    chk("abort_result", 256'(res0), 256'd0);
    idle(15);
    run0("after_reset", 1'b0, 255'd100, 255'd200, 255'd300, 1'b0);

    // small parameter set
    run1("w16_add_wrap", 1'b0, 16'd65520, 16'd1, 16'd0,     1'b1);
    run1("w16_sub_wrap", 1'b1, 16'd0,     16'd1, 16'd65520, 1'b1);
    run1("w16_add_max",  1'b0, 16'd65520, 16'd65520, 16'd65519, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      run1("w16_rand", 1'($urandom_range(0, 1)), 16'($urandom_range(0, P1 - 1)),
           16'($urandom_range(0, P1 - 1)), 16'd0, 1'b0);
    end
    idle(12);

    chk("q0_drained", 256'(exp_q0.size()), 256'd0);
    chk("q1_drained", 256'(exp_q1.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
